// File: rtl/ilv2_block_sched.sv
// ilv2_block_sched: block-granular round-robin scheduler that shares one
// 2-way interleaver between two FEC lane encoders. A lane is granted for a
// whole block; its words are registered onto the interleaver input with pair
// phase and start-of-block marks, and an owner tag is delayed ILV_LAT cycles
// so the downstream deinterleaver/demux can route recovered words.
//
// Optional feature: define ILV2_SCHED_STATS_EN to add per-lane block counters.
//
// Ports:
//   clk, sclr            clock, synchronous active-high reset
//   a_req/a_din/a_ack    lane A: block ready, word, word consumed
//   b_req/b_din/b_ack    lane B: block ready, word, word consumed
//   ilv_din/ilv_valid    registered word to interleaver and its valid
//   ilv_phase/ilv_sob    pair phase (0 even, 1 odd) and first word of block
//   own_valid/own_out    owner tag (0=A, 1=B) aligned to interleaver output
//   busy                 a block is in progress
//   a_blocks/b_blocks    completed blocks per lane (stats build only)
module ilv2_block_sched #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned BLOCK_WORDS = 64,
   parameter int unsigned ILV_LAT     = 2
) (
   input  logic             clk,
   input  logic             sclr,
   input  logic             a_req,
   input  logic [WIDTH-1:0] a_din,
   output logic             a_ack,
   input  logic             b_req,
   input  logic [WIDTH-1:0] b_din,
   output logic             b_ack,
   output logic [WIDTH-1:0] ilv_din,
   output logic             ilv_valid,
   output logic             ilv_phase,
   output logic             ilv_sob,
   output logic             own_valid,
   output logic             own_out,
   output logic             busy
`ifdef ILV2_SCHED_STATS_EN
   ,
   output logic [15:0]      a_blocks,
   output logic [15:0]      b_blocks
`endif
);

   localparam int unsigned CW = $clog2(BLOCK_WORDS);
   localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_WORDS - 1);

   // Elaboration-time parameter checks
   if (BLOCK_WORDS < 2 || (BLOCK_WORDS % 2) != 0) begin : g_bad_block_words
      $error("ilv2_block_sched: BLOCK_WORDS must be even and >= 2");
   end
   if (ILV_LAT < 1) begin : g_bad_ilv_lat
      $error("ilv2_block_sched: ILV_LAT must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    wcnt, wcnt_nxt;
   logic             last_own, last_own_nxt;
   logic             a_ack_nxt, b_ack_nxt, busy_nxt;
   logic [WIDTH-1:0] din_nxt;
   logic             valid_nxt, phase_nxt, sob_nxt, own_nxt;
   logic             ilv_own;
   logic [ILV_LAT-1:0] ov_pipe, oo_pipe;

   // Arbitration: a lone requester wins; on a tie the lane that did not own
   // the previous block wins (last_own=1 means B went last, so A wins).
   function automatic state_t arb(input logic a, input logic b, input logic lo);
      state_t s;
      if (a && b)  s = lo ? GNT_A : GNT_B;
      else if (a)  s = GNT_A;
      else if (b)  s = GNT_B;
      else         s = IDLE;
      return s;
   endfunction

   // Next-state and next-output logic
   always_comb begin
      state_nxt    = state;
      wcnt_nxt     = wcnt;
      last_own_nxt = last_own;
      din_nxt      = ilv_din;
      valid_nxt    = 1'b0;
      phase_nxt    = 1'b0;
      sob_nxt      = 1'b0;
      own_nxt      = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = arb(a_req, b_req, last_own);
         end
         GNT_A, GNT_B: begin
            own_nxt   = (state == GNT_B);
            valid_nxt = 1'b1;
            din_nxt   = own_nxt ? b_din : a_din;
            phase_nxt = wcnt[0];
            sob_nxt   = (wcnt == '0);
            if (wcnt == LAST_WORD) begin
               // Re-arbitrate on the last word so a winner follows with no bubble
               wcnt_nxt     = '0;
               last_own_nxt = own_nxt;
               state_nxt    = arb(a_req, b_req, own_nxt);
            end else begin
               wcnt_nxt = wcnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      a_ack_nxt = (state_nxt == GNT_A);
      b_ack_nxt = (state_nxt == GNT_B);
      busy_nxt  = (state_nxt != IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (sclr) begin
         state     <= IDLE;
         wcnt      <= '0;
         last_own  <= 1'b1;
         a_ack     <= 1'b0;
         b_ack     <= 1'b0;
         busy      <= 1'b0;
         ilv_din   <= '0;
         ilv_valid <= 1'b0;
         ilv_phase <= 1'b0;
         ilv_sob   <= 1'b0;
         ilv_own   <= 1'b0;
      end else begin
         state     <= state_nxt;
         wcnt      <= wcnt_nxt;
         last_own  <= last_own_nxt;
         a_ack     <= a_ack_nxt;
         b_ack     <= b_ack_nxt;
         busy      <= busy_nxt;
         ilv_din   <= din_nxt;
         ilv_valid <= valid_nxt;
         ilv_phase <= phase_nxt;
         ilv_sob   <= sob_nxt;
         ilv_own   <= own_nxt;
      end
   end

   // Owner tag pipeline, ILV_LAT stages behind the interleaver input register
   always_ff @(posedge clk) begin
      if (sclr) begin
         ov_pipe <= '0;
         oo_pipe <= '0;
      end else begin
         ov_pipe[0] <= ilv_valid;
         oo_pipe[0] <= ilv_own;
         for (int i = 1; i < int'(ILV_LAT); i++) begin
            ov_pipe[i] <= ov_pipe[i-1];
            oo_pipe[i] <= oo_pipe[i-1];
         end
      end
   end

   assign own_valid = ov_pipe[ILV_LAT-1];
   assign own_out   = oo_pipe[ILV_LAT-1];

`ifdef ILV2_SCHED_STATS_EN
   // Per-lane completed-block counters, bumped on each block's last word
   always_ff @(posedge clk) begin
      if (sclr) begin
         a_blocks <= '0;
         b_blocks <= '0;
      end else if (wcnt == LAST_WORD) begin
         if (state == GNT_A) a_blocks <= a_blocks + 16'd1;
         if (state == GNT_B) b_blocks <= b_blocks + 16'd1;
      end
   end
`endif

endmodule
